// File: rtl/byte_link_memory.sv
// rtl/byte_link_memory.sv - byte-framed memory and instruction-pointer partner for the CPU pin bus
//
// Accepts FETCH / READ / WRITE / SETPC frames one byte per cmd_valid cycle
// (multi-byte fields LSB first) and answers FETCH / READ with four data
// bytes, LSB first, one per cycle.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-low reset
//   cmd_valid  cmd_byte carries a byte this cycle
//   cmd_byte   header, address or write-data byte
//   rsp_valid  rsp_byte carries a response byte this cycle
//   rsp_byte   response byte, holds its value while rsp_valid is low
//   busy       a frame is in progress
//   overrun    sticky: a byte arrived while it could not be accepted
//   pc         current instruction pointer
module byte_link_memory #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  output logic        rsp_valid,
  output logic [7:0]  rsp_byte,
  output logic        busy,
  output logic        overrun,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_COMMIT, S_READ_MEM, S_RESP
  } state_t;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_SETPC = 2'b11;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] pc_q, pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_byte_q, rsp_byte_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic [31:0]       addr_shift;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    pc_d        = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_byte_d  = rsp_byte_q;
    overrun_d   = overrun_q;

    // FETCH reads at the pointer, READ at the assembled address.
    rd_idx     = (op_q == OP_FETCH) ? pc_q[ADDR_W+1:2] : addr_q[ADDR_W+1:2];
    rd_word    = mem[rd_idx];
    addr_shift = {cmd_byte, addr_q[31:8]};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_byte[1:0];
          cnt_d   = 2'd0;
          state_d = (cmd_byte[1:0] == OP_FETCH) ? S_READ_MEM : S_ADDR;
        end
      end
      S_ADDR: begin
        if (cmd_valid) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            case (op_q)
              OP_READ:  state_d = S_READ_MEM;
              OP_WRITE: state_d = S_WDATA;
              OP_SETPC: begin
                state_d = S_IDLE;
                pc_d    = addr_shift;
              end
              default:  state_d = S_IDLE;
            endcase
          end
        end
      end
      S_WDATA: begin
        if (cmd_valid) begin
          wdata_d = {cmd_byte, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      S_READ_MEM: begin
        // Byte 0 goes straight out; the rest wait in the shift register.
        rsp_valid_d = 1'b1;
        rsp_byte_d  = rd_word[7:0];
        shift_d     = {8'h00, rd_word[31:8]};
        cnt_d       = 2'd0;
        if (op_q == OP_FETCH) pc_d = pc_q + 32'd4;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (cnt_q == 2'd3) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          rsp_byte_d = shift_q[7:0];
          shift_d    = {8'h00, shift_q[31:8]};
          cnt_d      = cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cmd_valid && (state_q == S_COMMIT || state_q == S_READ_MEM || state_q == S_RESP))
      overrun_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_FETCH;
      cnt_q       <= 2'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      shift_q     <= 32'h0;
      pc_q        <= PC_RESET;
      rsp_valid_q <= 1'b0;
      rsp_byte_q  <= 8'h00;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_byte_q  <= rsp_byte_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // RAM is not reset; a reset during COMMIT suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && state_q == S_COMMIT)
      mem[addr_q[ADDR_W+1:2]] <= wdata_q;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_byte  = rsp_byte_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign pc        = pc_q;

endmodule
